// File: rtl/riscv_trace_buffer.sv
// Retire-trace capture buffer: circular history, trigger/post-capture freeze, oldest-first drain.
// Optional per-entry timestamps are built when TRACE_TIMESTAMP_EN is defined.

module riscv_trace_lane (
  input  logic        vld,
  input  logic        trig_en,
  input  logic [31:0] pc,
  input  logic [31:0] trig_pc,
  output logic        hit
);
  assign hit = vld & trig_en & (pc == trig_pc);
endmodule

module riscv_trace_buffer #(
  parameter int LANES = 2,
  parameter int DEPTH = 32,
  parameter int TS_W  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [LANES-1:0]         retire_valid_i,
  input  logic [32*LANES-1:0]      retire_pc_i,
  input  logic [32*LANES-1:0]      retire_instr_i,
  input  logic                     arm_i,
  input  logic                     trig_en_i,
  input  logic [31:0]              trig_pc_i,
  input  logic                     force_trig_i,
  input  logic [$clog2(DEPTH):0]   post_cnt_i,
  output logic                     rd_valid_o,
  input  logic                     rd_ready_i,
  output logic [31:0]              rd_pc_o,
  output logic [31:0]              rd_instr_o,
  output logic [TS_W-1:0]          rd_ts_o,
  output logic [1:0]               state_o,
  output logic                     wrapped_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_S = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, FROZEN = 2'd3} state_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  state_e                    state_q;
  logic [AW-1:0]             wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]             count_q, post_q;
  logic                      wrapped_q;
  entry_t                    mem [DEPTH];

  logic [LANES-1:0]          hit, we;
  logic [LANES-1:0][AW-1:0]  off;
  logic [CW-1:0]             n_wr;
  logic [CW:0]               sum, excess;
  logic                      trig, ovf, rd_fire;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    riscv_trace_lane u_lane (
      .vld     (retire_valid_i[k]),
      .trig_en (trig_en_i),
      .pc      (retire_pc_i[32*k +: 32]),
      .trig_pc (trig_pc_i),
      .hit     (hit[k])
    );
  end

  // Compact valid lanes in program order; in POST only the remaining budget is kept.
  always_comb begin
    we   = '0;
    off  = '0;
    n_wr = '0;
    for (int k = 0; k < LANES; k++) begin
      if (retire_valid_i[k] && !arm_i &&
          (state_q == ARMED || (state_q == POST && n_wr < post_q))) begin
        we[k]  = 1'b1;
        off[k] = n_wr[AW-1:0];
        n_wr   = n_wr + CW'(1);
      end
    end
  end

  assign trig    = (state_q == ARMED) && (force_trig_i || (|hit));
  assign sum     = {1'b0, count_q} + {1'b0, n_wr};
  assign ovf     = sum > DEPTH_S;
  assign excess  = sum - DEPTH_S;
  assign rd_fire = rd_valid_o & rd_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      post_q    <= '0;
      wrapped_q <= 1'b0;
    end else if (arm_i) begin
      state_q   <= ARMED;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      post_q    <= '0;
      wrapped_q <= 1'b0;
    end else begin
      case (state_q)
        ARMED, POST: begin
          wr_ptr_q <= wr_ptr_q + n_wr[AW-1:0];
          // Overflow drops the oldest entries so the window always ends at the newest write.
          if (ovf) begin
            rd_ptr_q  <= rd_ptr_q + excess[AW-1:0];
            count_q   <= DEPTH_S[CW-1:0];
            wrapped_q <= 1'b1;
          end else begin
            count_q <= sum[CW-1:0];
          end
          if (state_q == ARMED) begin
            if (trig) begin
              post_q  <= post_cnt_i;
              state_q <= (post_cnt_i == '0) ? FROZEN : POST;
            end
          end else begin
            post_q <= post_q - n_wr;
            if (post_q == n_wr) state_q <= FROZEN;
          end
        end
        FROZEN: begin
          if (rd_fire) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q  <= count_q - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;
  logic [TS_W-1:0] ts_mem [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ts_q <= '0;
    else         ts_q <= ts_q + TS_W'(1);
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < LANES; k++)
      if (we[k]) ts_mem[wr_ptr_q + off[k]] <= ts_q;
  end

  assign rd_ts_o = ts_mem[rd_ptr_q];
`else
  assign rd_ts_o = '0;
`endif

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < LANES; k++)
      if (we[k]) mem[wr_ptr_q + off[k]] <= '{pc: retire_pc_i[32*k +: 32], instr: retire_instr_i[32*k +: 32]};
  end

  assign rd_valid_o = (state_q == FROZEN) && (count_q != '0);
  assign rd_pc_o    = mem[rd_ptr_q].pc;
  assign rd_instr_o = mem[rd_ptr_q].instr;
  assign state_o    = state_q;
  assign wrapped_o  = wrapped_q;
  assign count_o    = count_q;
endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Directed bench for riscv_trace_buffer: capture, wrap, post-trigger budget, stalled drain, arm-clear, timestamps.
module tb_riscv_trace_buffer;
  localparam int LANES = 2;
  localparam int DEPTH = 32;
  localparam int TS_W  = 4;

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic [LANES-1:0]       retire_valid_i;
  logic [32*LANES-1:0]    retire_pc_i;
  logic [32*LANES-1:0]    retire_instr_i;
  logic                   arm_i;
  logic                   trig_en_i;
  logic [31:0]            trig_pc_i;
  logic                   force_trig_i;
  logic [5:0]             post_cnt_i;
  logic                   rd_valid_o;
  logic                   rd_ready_i;
  logic [31:0]            rd_pc_o;
  logic [31:0]            rd_instr_o;
  logic [TS_W-1:0]        rd_ts_o;
  logic [1:0]             state_o;
  logic                   wrapped_o;
  logic [5:0]             count_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  riscv_trace_buffer #(.LANES(LANES), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .retire_valid_i(retire_valid_i),
    .retire_pc_i(retire_pc_i), .retire_instr_i(retire_instr_i), .arm_i(arm_i),
    .trig_en_i(trig_en_i), .trig_pc_i(trig_pc_i), .force_trig_i(force_trig_i),
    .post_cnt_i(post_cnt_i), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
    .rd_pc_o(rd_pc_o), .rd_instr_o(rd_instr_o), .rd_ts_o(rd_ts_o),
    .state_o(state_o), .wrapped_o(wrapped_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic ret(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1);
    retire_valid_i = v;
    retire_pc_i    = {p1, p0};
    retire_instr_i = {p1 ^ 32'hA5A5_0000, p0 ^ 32'hA5A5_0000};
    cyc();
    retire_valid_i = '0;
  endtask

  task automatic arm();
    arm_i = 1'b1;
    retire_valid_i = 2'b11;
    retire_pc_i = {32'hDEAD_0004, 32'hDEAD_0000};
    cyc();
    arm_i = 1'b0;
    retire_valid_i = '0;
    chk("arm_state", 32'(state_o), 32'd1);
    chk("arm_count", 32'(count_o), 32'd0);
  endtask

  // Drain exp_q with a repeating 4-cycle ready pattern (bit i = cycle i).
  task automatic drain(input int n, input logic [3:0] pat, input bit ts_mode);
    int j = 0;
    int p = 0;
    int guard = 0;
    logic [TS_W-1:0] last_ts = '0;
    bit wrap_seen = 1'b0;
    while (j < n && guard < 300) begin
      rd_ready_i = pat[p % 4];
      chk("drain_valid", 32'(rd_valid_o), 32'd1);
      chk("drain_pc", rd_pc_o, exp_q[j]);
      chk("drain_instr", rd_instr_o, exp_q[j] ^ 32'hA5A5_0000);
`ifdef TRACE_TIMESTAMP_EN
      if (ts_mode && rd_ready_i) begin
        if (j > 0) begin
          chk("ts_step", 32'(rd_ts_o), 32'(TS_W'(last_ts + TS_W'(1))));
          if (rd_ts_o == '0) wrap_seen = 1'b1;
        end
        last_ts = rd_ts_o;
      end
`else
      chk("ts_zero", 32'(rd_ts_o), 32'd0);
`endif
      if (rd_ready_i) j++;
      p++;
      guard++;
      cyc();
    end
    if (j < n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: observed %0d entries expected %0d", j, n);
    end
    rd_ready_i = 1'b0;
    chk("drain_done_valid", 32'(rd_valid_o), 32'd0);
    chk("drain_done_count", 32'(count_o), 32'd0);
    chk("drain_done_state", 32'(state_o), 32'd3);
`ifdef TRACE_TIMESTAMP_EN
    if (ts_mode) chk("ts_wrap_seen", 32'(wrap_seen), 32'd1);
`endif
  endtask

  initial begin
    rst_ni = 1'b0;
    retire_valid_i = 2'b11;
    retire_pc_i = {32'h0000_0F04, 32'h0000_0F00};
    retire_instr_i = '0;
    arm_i = 1'b0;
    trig_en_i = 1'b0;
    trig_pc_i = '0;
    force_trig_i = 1'b0;
    post_cnt_i = '0;
    rd_ready_i = 1'b0;

    // Reset with traffic, then traffic without arm.
    repeat (3) cyc();
    rst_ni = 1'b1;
    repeat (3) cyc();
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_valid", 32'(rd_valid_o), 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_wrapped", 32'(wrapped_o), 32'd0);
    retire_valid_i = '0;

    // A: 20 entries, forced trigger, no post.
    arm();
    for (int i = 0; i < 10; i++) begin
      force_trig_i = (i == 9);
      ret(2'b11, 32'h100 + 8*i, 32'h104 + 8*i);
    end
    force_trig_i = 1'b0;
    chk("a_state", 32'(state_o), 32'd3);
    chk("a_count", 32'(count_o), 32'd20);
    chk("a_wrapped", 32'(wrapped_o), 32'd0);
    exp_q.delete();
    for (int j = 0; j < 20; j++) exp_q.push_back(32'h100 + 4*j);
    drain(20, 4'b1111, 1'b0);

    // B: 80 entries into 32, PC trigger on lane 1 of the last cycle.
    arm();
    trig_en_i = 1'b1;
    trig_pc_i = 32'h113C;
    for (int i = 0; i < 40; i++) begin
      ret(2'b11, 32'h1000 + 8*i, 32'h1004 + 8*i);
      if (i == 38) chk("b_still_armed", 32'(state_o), 32'd1);
    end
    trig_en_i = 1'b0;
    chk("b_state", 32'(state_o), 32'd3);
    chk("b_count", 32'(count_o), 32'd32);
    chk("b_wrapped", 32'(wrapped_o), 32'd1);
    exp_q.delete();
    for (int j = 0; j < 32; j++) exp_q.push_back(32'h10C0 + 4*j);
    drain(32, 4'b1111, 1'b0);

    // C: post budget of 3, fourth lane dropped, later triggers ignored.
    arm();
    trig_en_i = 1'b1;
    trig_pc_i = 32'h200;
    post_cnt_i = 6'd3;
    ret(2'b11, 32'h1F8, 32'h1FC);
    chk("c_pre_state", 32'(state_o), 32'd1);
    ret(2'b11, 32'h200, 32'h204);
    chk("c_trig_state", 32'(state_o), 32'd2);
    chk("c_trig_count", 32'(count_o), 32'd4);
    ret(2'b11, 32'h208, 32'h20C);
    chk("c_post_state", 32'(state_o), 32'd2);
    chk("c_post_count", 32'(count_o), 32'd6);
    ret(2'b11, 32'h210, 32'h214);
    chk("c_frozen_state", 32'(state_o), 32'd3);
    chk("c_frozen_count", 32'(count_o), 32'd7);
    trig_en_i = 1'b0;
    post_cnt_i = '0;
    force_trig_i = 1'b1;
    ret(2'b11, 32'h400, 32'h404);
    force_trig_i = 1'b0;
    chk("c_ignore_count", 32'(count_o), 32'd7);
    chk("c_ignore_state", 32'(state_o), 32'd3);

    // D: drain C with a stalling consumer.
    exp_q.delete();
    for (int j = 0; j < 7; j++) exp_q.push_back(32'h1F8 + 4*j);
    drain(7, 4'b1001, 1'b0);

    // E: arm coincident with a read handshake mid-drain.
    arm();
    for (int i = 0; i < 3; i++) begin
      force_trig_i = (i == 2);
      ret(2'b11, 32'h500 + 8*i, 32'h504 + 8*i);
    end
    force_trig_i = 1'b0;
    chk("e_count", 32'(count_o), 32'd6);
    rd_ready_i = 1'b1;
    repeat (2) cyc();
    chk("e_mid_count", 32'(count_o), 32'd4);
    chk("e_mid_pc", rd_pc_o, 32'h508);
    arm_i = 1'b1;
    cyc();
    arm_i = 1'b0;
    rd_ready_i = 1'b0;
    chk("e_arm_count", 32'(count_o), 32'd0);
    chk("e_arm_state", 32'(state_o), 32'd1);
    chk("e_arm_valid", 32'(rd_valid_o), 32'd0);

    // F: 20 single-lane cycles alternating lanes; timestamps step each entry.
    for (int i = 0; i < 20; i++) begin
      force_trig_i = (i == 19);
      if (i % 2 == 1) ret(2'b10, 32'hBAD, 32'h300 + 4*i);
      else            ret(2'b01, 32'h300 + 4*i, 32'hBAD);
    end
    force_trig_i = 1'b0;
    chk("f_count", 32'(count_o), 32'd20);
    chk("f_state", 32'(state_o), 32'd3);
    exp_q.delete();
    for (int j = 0; j < 20; j++) exp_q.push_back(32'h300 + 4*j);
    drain(20, 4'b1011, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/riscv_trace_buffer.md
Name: riscv_trace_buffer

Overview:
- Parametrised retire-trace capture buffer for the dual-issue core.
- Records up to LANES retired instructions per cycle (pc, instr, optional timestamp) into a circular DEPTH-entry history.
- Freezes a programmable number of entries after a PC-match or forced trigger, then drains oldest-first over a valid/ready port to the sim/debug harness.
- Sits beside the retire stage; passive, never stalls the pipeline.

Parameters:
- LANES, 2, retire lanes sampled per cycle (1..4); lane 0 is oldest in program order.
- DEPTH, 32, buffer entries; power of 2, >= 2*LANES.
- TS_W, 16, timestamp counter width.

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  asynchronous active-low reset
- retire_valid_i  in  LANES  per-lane retire valid
- retire_pc_i  in  32*LANES  lane k at [32k+31:32k]
- retire_instr_i  in  32*LANES  lane k at [32k+31:32k]
- arm_i  in  1  pulse: clear buffer, start capture
- trig_en_i  in  1  enable PC-match trigger
- trig_pc_i  in  32  trigger PC
- force_trig_i  in  1  immediate trigger
- post_cnt_i  in  log2(DEPTH)+1  entries captured after the trigger cycle, sampled at trigger
- rd_valid_o  out  1  entry available
- rd_ready_i  in  1  consumer accepts entry
- rd_pc_o  out  32  oldest entry PC
- rd_instr_o  out  32  oldest entry instr
- rd_ts_o  out  TS_W  oldest entry timestamp
- state_o  out  2  0 IDLE, 1 ARMED, 2 POST, 3 FROZEN
- wrapped_o  out  1  sticky: at least one entry overwritten since arm
- count_o  out  log2(DEPTH)+1  valid entries held

Behaviour:
- Reset (async, any state): state IDLE; wr_ptr, rd_ptr, count, post counter, timestamp = 0; rd_valid_o = 0; wrapped_o = 0. Data outputs are don't-care while rd_valid_o = 0.
- arm_i (any state): on the next edge, pointers, count and wrapped_o clear and state becomes ARMED. Retire lanes in the arm cycle are not captured.
- ARMED/POST capture:
  - Valid lanes are compacted in lane order and written at wr_ptr, wr_ptr+1, ... (mod DEPTH) on the same edge; up to LANES writes per cycle.
  - When count + n > DEPTH, the oldest entries are overwritten: rd_ptr advances by the excess, count saturates at DEPTH, wrapped_o sets.
- Trigger (ARMED only): any valid lane with trig_en_i and pc == trig_pc_i, or force_trig_i.
  - All valid lanes of the trigger cycle are written.
  - post counter loads post_cnt_i.
  - Next state is POST, or FROZEN if post_cnt_i == 0.
  - Triggers in POST/FROZEN/IDLE are ignored.
- POST:
  - Per cycle, write min(n_valid, remaining) lanes in lane order; excess lanes are dropped.
  - Decrement by the number written; at 0, FROZEN on that edge.
- FROZEN:
  - No captures. rd_valid_o = (count != 0).
  - rd_* reflect entry rd_ptr combinationally from storage.
  - On rd_valid_o & rd_ready_i: rd_ptr+1 mod DEPTH, count-1. Data stay stable while rd_valid_o & !rd_ready_i.
  - After drain, remain FROZEN with rd_valid_o = 0 until arm_i.
- IDLE/ARMED/POST: rd_valid_o = 0; rd_ready_i is ignored.
- Timestamp: free-running TS_W counter from reset, wraps silently to 0. Entry ts = counter value at its write edge; lanes in the same cycle share a ts.
- arm_i coincident with a trigger or a read handshake: arm wins; clear takes precedence.

Optional Feature:
- Macro TRACE_TIMESTAMP_EN.
- Defined: timestamp counter and per-entry TS_W storage are built; rd_ts_o as above.
- Undefined: no counter or storage is built; rd_ts_o ties to 0. All other behaviour is identical.

Test Plan:
- Reset with retire traffic active, then release: state_o=0, rd_valid_o=0, count_o=0, wrapped_o=0; no captures until arm_i.
- Arm; retire 10 cycles of both lanes (pc 0x100 + 4i); force_trig_i with post_cnt_i=0 on the 10th: FROZEN, count_o=20, drain yields pc 0x100..0x14C in order, wrapped_o=0.
- Arm; 40 cycles of dual retire (80 entries, DEPTH=32), trigger via trig_pc_i matching lane 1 of cycle 40, post_cnt_i=0: count_o=32, first drained pc is the 49th retired, wrapped_o=1.
- trig_pc_i=0x200 matches lane 0; post_cnt_i=3; next cycle both valid, following cycle both valid: exactly 3 post entries kept, 4th lane dropped, FROZEN.
- Drain with rd_ready_i toggling 1,0,0,1: rd_pc_o is held during stall, each entry appears once, rd_valid_o falls after the last entry; then arm_i mid-drain clears count_o to 0 and state_o becomes 1.
- TRACE_TIMESTAMP_EN defined, TS_W=4: a capture spanning 20 cycles shows ts wrapping 15 to 0; undefined build shows rd_ts_o=0 throughout.
